rx_unit: RTL and testbench
==========================

RX_UNIT -- requirements
Module: rx_unit

Interface
REQ-001 SHALL have parameter RX_DATA_SIZE, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10416, i_clock cycles per serial bit (even, >= 8).
REQ-003 i_clock  input  1  single clock; all state on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_rx_0, i_rx_1  input  1 each  serial lines, idle high.
REQ-006 o_rxdata_0, o_rxdata_1  output  RX_DATA_SIZE each  last good received word.
REQ-007 o_rx_valid_0, o_rx_valid_1  output  1 each  one-cycle pulse, new word.
REQ-008 o_frame_err_0, o_frame_err_1  output  1 each  one-cycle pulse, stop bit low.

Function
REQ-009 Each channel SHALL be an independent receiver; no interaction between channels.
REQ-010 Frame format SHALL be 1 start (low), RX_DATA_SIZE data bits LSB first, 1 stop (high), no parity.
REQ-011 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: on sampled line low, go to START with bit counter cleared.
REQ-013 START: after CLKS_PER_BIT/2 cycles resample; low -> DATA, high -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: sample every CLKS_PER_BIT cycles (mid-bit), shift into register LSB first; after RX_DATA_SIZE samples -> STOP.
REQ-015 STOP: sample after CLKS_PER_BIT cycles; high -> load o_rxdata, pulse o_rx_valid next cycle, go IDLE.
REQ-016 STOP sample low -> pulse o_frame_err, o_rxdata unchanged, go WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until sampled line high, then IDLE (break condition yields exactly one o_frame_err).
REQ-018 o_rx_valid and o_frame_err SHALL never assert in the same cycle and SHALL be exactly one cycle wide.
REQ-019 o_rxdata SHALL change only in the cycle o_rx_valid asserts, and hold otherwise.
REQ-020 Line low immediately after STOP completes SHALL be accepted as next start bit (back-to-back frames, no idle gap required).
REQ-021 Baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and reload on every state transition.

Reset
REQ-022 While i_reset_n low: state IDLE, counters 0, shift register 0, o_rxdata 0, o_rx_valid 0, o_frame_err 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, a low line SHALL be treated as a new start bit.
REQ-024 Synchronizer flops (when present) SHALL reset to 1 (idle).

Configuration
REQ-025 Macro RX_UNIT_SYNC_EN defined: each i_rx SHALL pass a 2-flop synchronizer before the FSM; all sample points shift 2 cycles later.
REQ-026 Macro RX_UNIT_SYNC_EN undefined: FSM SHALL sample i_rx directly; no other behaviour change.

Structure
REQ-027 State encoding constants and default CLKS_PER_BIT SHALL reside in shared package rx_unit_pkg.
REQ-028 Per-channel logic SHALL be sub-module uart_rx_core (parameters RX_DATA_SIZE, CLKS_PER_BIT), instantiated twice in rx_unit.

Verification (CLKS_PER_BIT=16, RX_DATA_SIZE=8)
REQ-029 Channel 0 sends 0xA5 with good stop -> o_rxdata_0=0xA5, one o_rx_valid_0 pulse, o_frame_err_0 never high, channel 1 outputs static.
REQ-030 Channel 1 sends 0x3C then 0xFF back-to-back with no idle gap -> two o_rx_valid_1 pulses, o_rxdata_1 = 0x3C then 0xFF.
REQ-031 Channel 0 sends 0x81 with stop bit low -> one o_frame_err_0 pulse, o_rxdata_0 retains previous value, no o_rx_valid_0.
REQ-032 Channel 0 line low for 4 cycles then high -> returns to IDLE, no pulses; following 0x12 frame received correctly.
REQ-033 i_reset_n pulsed low during data bit 3 of a frame -> no pulses, outputs 0; next full frame 0x5A received correctly.
REQ-034 Both channels receive 0x00 and 0xFF simultaneously -> both o_rx_valid pulse in the same cycle, data correct; repeated with RX_UNIT_SYNC_EN defined -> pulses exactly 2 cycles later.

Source files
------------

// File: rtl/rx_unit_pkg.sv
// Shared constants and FSM state encoding for the dual-channel UART receiver.
// Pure declarations: no latency or flow-control behaviour of its own.
package rx_unit_pkg;

  localparam int RX_DEFAULT_CLKS_PER_BIT = 10416;
  localparam int RX_DEFAULT_DATA_SIZE    = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// Single-channel 8N1-style receiver: mid-bit sampling, glitch-rejecting start, break hold-off.
// Word/error pulse one cycle after the stop sample (+2 with RX_UNIT_SYNC_EN); no backpressure.
module uart_rx_core
  import rx_unit_pkg::*;
#(
  parameter int RX_DATA_SIZE = RX_DEFAULT_DATA_SIZE,
  parameter int CLKS_PER_BIT = RX_DEFAULT_CLKS_PER_BIT
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    rx,
  output logic [RX_DATA_SIZE-1:0] rxdata,
  output logic                    rx_valid,
  output logic                    frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(RX_DATA_SIZE + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(RX_DATA_SIZE - 1);

  rx_state_t               state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [RX_DATA_SIZE-1:0] shreg;
  logic                    rx_s;
  logic                    baud_done;
  logic                    cnt_run, shift_en, load_word, err_set;

`ifdef RX_UNIT_SYNC_EN
  logic [1:0] sync_q;

  // Reset to idle-high so a reset release never looks like a start edge.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  assign baud_done = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!rx_s) state_nxt = ST_START;
      ST_START:     if (baud_done) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (baud_done && (bit_cnt == DATA_LAST)) state_nxt = ST_STOP;
      ST_STOP:      if (baud_done) state_nxt = rx_s ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_s) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_run   = 1'b0;
    shift_en  = 1'b0;
    load_word = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_START: cnt_run = 1'b1;
      ST_DATA: begin
        cnt_run  = 1'b1;
        shift_en = baud_done;
      end
      ST_STOP: begin
        cnt_run   = 1'b1;
        load_word = baud_done && rx_s;
        err_set   = baud_done && !rx_s;
      end
      default: ;
    endcase
  end

  // Counter restarts on every sample so each later sample lands mid-bit.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rxdata    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load_word;
      frame_err <= err_set;
      if (!cnt_run || baud_done || (state_nxt != state)) cnt <= '0;
      else                                               cnt <= cnt + 1'b1;
      if (state == ST_IDLE) bit_cnt <= '0;
      else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)  shreg  <= {rx_s, shreg[RX_DATA_SIZE-1:1]};
      if (load_word) rxdata <= shreg;
    end
  end

endmodule

// File: rtl/rx_unit.sv
// Two independent UART receive channels; optional input synchronizers via RX_UNIT_SYNC_EN.
// Word/error pulse one cycle after the stop sample (+2 with RX_UNIT_SYNC_EN); no backpressure.
module rx_unit
  import rx_unit_pkg::*;
#(
  parameter int RX_DATA_SIZE = RX_DEFAULT_DATA_SIZE,
  parameter int CLKS_PER_BIT = RX_DEFAULT_CLKS_PER_BIT
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_rx_0,
  input  logic                    i_rx_1,
  output logic [RX_DATA_SIZE-1:0] o_rxdata_0,
  output logic [RX_DATA_SIZE-1:0] o_rxdata_1,
  output logic                    o_rx_valid_0,
  output logic                    o_rx_valid_1,
  output logic                    o_frame_err_0,
  output logic                    o_frame_err_1
);

  uart_rx_core #(
    .RX_DATA_SIZE (RX_DATA_SIZE),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ch0 (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .rx        (i_rx_0),
    .rxdata    (o_rxdata_0),
    .rx_valid  (o_rx_valid_0),
    .frame_err (o_frame_err_0)
  );

  uart_rx_core #(
    .RX_DATA_SIZE (RX_DATA_SIZE),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ch1 (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .rx        (i_rx_1),
    .rxdata    (o_rxdata_1),
    .rx_valid  (o_rx_valid_1),
    .frame_err (o_frame_err_1)
  );

endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit at CLKS_PER_BIT=16, RX_DATA_SIZE=8.
// Expected pulse timing also follows RX_UNIT_SYNC_EN when that macro is defined.
module tb_rx_unit;

  localparam int CPB = 16;
  localparam int DW  = 8;
  // Line-low to pulse: 1 detect edge + CPB/2 start + 9 bit periods (+2 synchronizer).
`ifdef RX_UNIT_SYNC_EN
  localparam int LAT = 155;
`else
  localparam int LAT = 153;
`endif

  logic          i_clock   = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_rx_0    = 1'b1;
  logic          i_rx_1    = 1'b1;
  logic [DW-1:0] o_rxdata_0, o_rxdata_1;
  logic          o_rx_valid_0, o_rx_valid_1, o_frame_err_0, o_frame_err_1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int vcnt[2], ecnt[2], vcyc[2], ecyc[2], vs[2], es[2];
  int both_hi = 0, wide = 0, glitch = 0, rst_pulse = 0;
  logic [DW-1:0] vlog0[$], vlog1[$];
  logic [1:0]    pv = '0, pe = '0;
  logic [DW-1:0] prev[2];

  rx_unit #(.RX_DATA_SIZE(DW), .CLKS_PER_BIT(CPB)) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_rx_0        (i_rx_0),
    .i_rx_1        (i_rx_1),
    .o_rxdata_0    (o_rxdata_0),
    .o_rxdata_1    (o_rxdata_1),
    .o_rx_valid_0  (o_rx_valid_0),
    .o_rx_valid_1  (o_rx_valid_1),
    .o_frame_err_0 (o_frame_err_0),
    .o_frame_err_1 (o_frame_err_1)
  );

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc++;

  // Pulse logger, sampled on the falling edge.
  always @(negedge i_clock) begin
    logic [1:0]    v, e;
    logic [DW-1:0] d[2];
    v = {o_rx_valid_1, o_rx_valid_0};
    e = {o_frame_err_1, o_frame_err_0};
    d[0] = o_rxdata_0;
    d[1] = o_rxdata_1;
    if (!i_reset_n) begin
      if (v != 2'b00 || e != 2'b00) rst_pulse++;
      pv = '0; pe = '0;
      prev[0] = d[0]; prev[1] = d[1];
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (v[c]) begin vcnt[c]++; vcyc[c] = cyc; end
        if (e[c]) begin ecnt[c]++; ecyc[c] = cyc; end
        if (v[c] && e[c]) both_hi++;
        if ((v[c] && pv[c]) || (e[c] && pe[c])) wide++;
        if (d[c] !== prev[c] && !v[c]) glitch++;
        prev[c] = d[c];
      end
      if (v[0]) vlog0.push_back(d[0]);
      if (v[1]) vlog1.push_back(d[1]);
      pv = v; pe = e;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clock); #1; end
  endtask

  task automatic snap();
    for (int c = 0; c < 2; c++) begin vs[c] = vcnt[c]; es[c] = ecnt[c]; end
  endtask

  task automatic send_frame(input int ch, input logic [DW-1:0] d, input logic stop_bit);
    logic [DW+1:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < DW + 2; i++) begin
      if (ch == 0) i_rx_0 = bits[i];
      else         i_rx_1 = bits[i];
      tick(CPB);
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    tick(3);
    tests++; if (o_rxdata_0 !== 8'h00) begin fails++; $display("FAIL reset_rxdata0: got %h want 00", o_rxdata_0); end
    tests++; if (o_rxdata_1 !== 8'h00) begin fails++; $display("FAIL reset_rxdata1: got %h want 00", o_rxdata_1); end
    tests++; if ({o_rx_valid_0, o_rx_valid_1, o_frame_err_0, o_frame_err_1} !== 4'b0000) begin
      fails++; $display("FAIL reset_pulses: got %b want 0000", {o_rx_valid_0, o_rx_valid_1, o_frame_err_0, o_frame_err_1}); end
    i_reset_n = 1'b1;
    tick(20);
    tests++; if (vcnt[0] + vcnt[1] + ecnt[0] + ecnt[1] !== 0) begin
      fails++; $display("FAIL idle_pulses: got %0d want 0", vcnt[0] + vcnt[1] + ecnt[0] + ecnt[1]); end
  endtask

  task automatic test_good_frame();
    int st;
    snap(); st = cyc;
    send_frame(0, 8'hA5, 1'b1);
    tick(4);
    tests++; if (o_rxdata_0 !== 8'hA5) begin fails++; $display("FAIL good_data0: got %h want a5", o_rxdata_0); end
    tests++; if (vcnt[0] - vs[0] !== 1) begin fails++; $display("FAIL good_valid0: got %0d pulses want 1", vcnt[0] - vs[0]); end
    tests++; if (ecnt[0] - es[0] !== 0) begin fails++; $display("FAIL good_err0: got %0d pulses want 0", ecnt[0] - es[0]); end
    tests++; if (vcyc[0] - st !== LAT) begin fails++; $display("FAIL good_latency: got %0d want %0d", vcyc[0] - st, LAT); end
    tests++; if ((vcnt[1] - vs[1]) + (ecnt[1] - es[1]) !== 0 || o_rxdata_1 !== 8'h00) begin
      fails++; $display("FAIL good_ch1_static: got %0d pulses data %h want 0 pulses data 00", (vcnt[1] - vs[1]) + (ecnt[1] - es[1]), o_rxdata_1); end
  endtask

  task automatic test_back_to_back();
    int st, q0;
    logic [DW-1:0] w0, w1;
    snap(); st = cyc; q0 = vlog1.size();
    send_frame(1, 8'h3C, 1'b1);
    send_frame(1, 8'hFF, 1'b1);
    tick(4);
    w0 = (vlog1.size() > q0)     ? vlog1[q0]     : 8'hxx;
    w1 = (vlog1.size() > q0 + 1) ? vlog1[q0 + 1] : 8'hxx;
    tests++; if (vcnt[1] - vs[1] !== 2) begin fails++; $display("FAIL b2b_count: got %0d pulses want 2", vcnt[1] - vs[1]); end
    tests++; if (w0 !== 8'h3C) begin fails++; $display("FAIL b2b_word0: got %h want 3c", w0); end
    tests++; if (w1 !== 8'hFF) begin fails++; $display("FAIL b2b_word1: got %h want ff", w1); end
    tests++; if (vcyc[1] - st !== CPB * (DW + 2) + LAT) begin
      fails++; $display("FAIL b2b_latency: got %0d want %0d", vcyc[1] - st, CPB * (DW + 2) + LAT); end
    tests++; if (vcnt[0] - vs[0] !== 0 || ecnt[1] - es[1] !== 0) begin
      fails++; $display("FAIL b2b_stray: got v0=%0d e1=%0d want 0 0", vcnt[0] - vs[0], ecnt[1] - es[1]); end
  endtask

  task automatic test_frame_err();
    int st;
    snap(); st = cyc;
    send_frame(0, 8'h81, 1'b0);
    tick(40);
    i_rx_0 = 1'b1;
    tick(40);
    tests++; if (ecnt[0] - es[0] !== 1) begin fails++; $display("FAIL ferr_count: got %0d pulses want 1", ecnt[0] - es[0]); end
    tests++; if (vcnt[0] - vs[0] !== 0) begin fails++; $display("FAIL ferr_valid: got %0d pulses want 0", vcnt[0] - vs[0]); end
    tests++; if (o_rxdata_0 !== 8'hA5) begin fails++; $display("FAIL ferr_hold: got %h want a5", o_rxdata_0); end
    tests++; if (ecyc[0] - st !== LAT) begin fails++; $display("FAIL ferr_latency: got %0d want %0d", ecyc[0] - st, LAT); end
  endtask

  task automatic test_glitch();
    snap();
    i_rx_0 = 1'b0;
    tick(4);
    i_rx_0 = 1'b1;
    tick(40);
    tests++; if ((vcnt[0] - vs[0]) + (ecnt[0] - es[0]) !== 0) begin
      fails++; $display("FAIL glitch_pulses: got %0d want 0", (vcnt[0] - vs[0]) + (ecnt[0] - es[0])); end
    snap();
    send_frame(0, 8'h12, 1'b1);
    tick(4);
    tests++; if (vcnt[0] - vs[0] !== 1) begin fails++; $display("FAIL glitch_next_count: got %0d want 1", vcnt[0] - vs[0]); end
    tests++; if (o_rxdata_0 !== 8'h12) begin fails++; $display("FAIL glitch_next_data: got %h want 12", o_rxdata_0); end
  endtask

  task automatic test_reset_midframe();
    int st;
    logic [DW-1:0] d;
    d = 8'h5A;
    snap();
    i_rx_0 = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin i_rx_0 = d[i]; tick(CPB); end
    i_rx_0 = d[3];
    tick(CPB / 2);
    i_reset_n = 1'b0;
    tick(3);
    tests++; if (o_rxdata_0 !== 8'h00 || o_rxdata_1 !== 8'h00) begin
      fails++; $display("FAIL rst_mid_data: got %h %h want 00 00", o_rxdata_0, o_rxdata_1); end
    i_reset_n = 1'b1;
    i_rx_0 = 1'b1;
    tick(200);
    tests++; if ((vcnt[0] - vs[0]) + (ecnt[0] - es[0]) + (vcnt[1] - vs[1]) + (ecnt[1] - es[1]) !== 0) begin
      fails++; $display("FAIL rst_mid_pulses: got %0d want 0", (vcnt[0] - vs[0]) + (ecnt[0] - es[0]) + (vcnt[1] - vs[1]) + (ecnt[1] - es[1])); end
    snap(); st = cyc;
    send_frame(0, 8'h5A, 1'b1);
    tick(4);
    tests++; if (o_rxdata_0 !== 8'h5A || vcnt[0] - vs[0] !== 1) begin
      fails++; $display("FAIL rst_mid_next: got data %h pulses %0d want 5a 1", o_rxdata_0, vcnt[0] - vs[0]); end
    tests++; if (vcyc[0] - st !== LAT) begin fails++; $display("FAIL rst_mid_latency: got %0d want %0d", vcyc[0] - st, LAT); end
  endtask

  task automatic test_simultaneous();
    int st;
    snap(); st = cyc;
    fork
      send_frame(0, 8'h00, 1'b1);
      send_frame(1, 8'hFF, 1'b1);
    join
    tick(4);
    tests++; if (vcnt[0] - vs[0] !== 1 || vcnt[1] - vs[1] !== 1) begin
      fails++; $display("FAIL sim_counts: got %0d %0d want 1 1", vcnt[0] - vs[0], vcnt[1] - vs[1]); end
    tests++; if (vcyc[0] !== vcyc[1]) begin fails++; $display("FAIL sim_same_cycle: got %0d vs %0d want equal", vcyc[0], vcyc[1]); end
    tests++; if (vcyc[0] - st !== LAT) begin fails++; $display("FAIL sim_latency: got %0d want %0d", vcyc[0] - st, LAT); end
    tests++; if (o_rxdata_0 !== 8'h00 || o_rxdata_1 !== 8'hFF) begin
      fails++; $display("FAIL sim_data: got %h %h want 00 ff", o_rxdata_0, o_rxdata_1); end
  endtask

  task automatic test_integrity();
    tests++; if (both_hi !== 0) begin fails++; $display("FAIL valid_err_overlap: got %0d want 0", both_hi); end
    tests++; if (wide !== 0) begin fails++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide); end
    tests++; if (glitch !== 0) begin fails++; $display("FAIL data_hold: got %0d unqualified changes want 0", glitch); end
    tests++; if (rst_pulse !== 0) begin fails++; $display("FAIL reset_pulse: got %0d want 0", rst_pulse); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_simultaneous();
    test_integrity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
